// File: rtl/ifu_pc_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pc_pkg
// Shared types and constants for the fetch-side PC generator (ifu_pc) and its
// FIFO helper (ifu_fifo).
//   inst_bus_t / inst_addr_bus_t : 32-bit instruction word / address
//   CPU_RESET_ADDR               : default PC after reset
//   JUMP_ENABLE                  : active level of the redirect strobes
//   IFU_NOP                      : addi x0,x0,0, shown when no instruction
//   tag_t                        : in-flight fetch record {epoch, addr}
//   buf_t                        : buffered instruction {inst, addr}
// Optional build macro: IFU_MISALIGN_CHK_EN (keeps target bit1 and flags
// misaligned redirect targets instead of fetching them).
// ---------------------------------------------------------------------------
package ifu_pc_pkg;

   typedef logic [31:0] inst_bus_t;
   typedef logic [31:0] inst_addr_bus_t;

   localparam inst_addr_bus_t CPU_RESET_ADDR = 32'h0000_0000;
   localparam logic           JUMP_ENABLE    = 1'b1;
   localparam inst_bus_t      IFU_NOP        = 32'h0000_0013;

   typedef struct packed {
      logic           epoch;
      inst_addr_bus_t addr;
   } tag_t;

   typedef struct packed {
`ifdef IFU_MISALIGN_CHK_EN
      logic           misalign;
`endif
      inst_bus_t      inst;
      inst_addr_bus_t addr;
   } buf_t;

   // Redirect targets are halfword aligned at most. Without the misalignment
   // check the fetch unit only handles word addresses, so bit1 is dropped too.
   function automatic inst_addr_bus_t align_target(input inst_addr_bus_t raw);
`ifdef IFU_MISALIGN_CHK_EN
      return {raw[31:1], 1'b0};
`else
      return {raw[31:2], 2'b00};
`endif
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Small synchronous FIFO used for the in-flight fetch tags and for the
// instruction buffer of ifu_pc.
//   clk, rst : clock, synchronous active-high reset
//   flush    : drop all stored entries this edge; a push in the same cycle
//              lands in the emptied FIFO
//   push     : write wdata (ignored when full and not popping/flushing)
//   pop      : discard head (ignored when empty or flushing)
//   rdata    : head entry (meaningless while empty)
//   empty    : no entries stored
//   count    : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ifu_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    wr_idx;
   logic [AW:0]      cnt;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (cnt != '0) && !flush;
   assign do_push = push && (flush || (cnt != FULL_CNT) || do_pop);
   // After a flush the pointers restart at zero, so a concurrent push goes there.
   assign wr_idx  = flush ? '0 : wr_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= do_push ? AW'(1) : '0;
         cnt    <= do_push ? (AW+1)'(1) : '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_idx] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign empty = (cnt == '0);
   assign count = cnt;

endmodule

// File: rtl/ifu_pc.sv
// ---------------------------------------------------------------------------
// ifu_pc
// Fetch PC generator and instruction-bus front end feeding if_id.
//   clk, rst                    : clock, synchronous active-high reset
//   ex_jump_en_i/ex_jump_addr_i : EX redirect (highest priority)
//   prd_jump_en_i, prd_jump_base_i, prd_jump_ofset_i : predicted redirect,
//                                 target = base + ofset
//   stall_i                     : if_id does not accept the head this cycle
//   ibus_req_o/ibus_addr_o      : fetch request at the current PC
//   ibus_gnt_i                  : request accepted this cycle
//   ibus_rvalid_i/ibus_rdata_i  : in-order response, >=1 cycle after gnt
//   inst_valid_o/inst_o/instaddr_o : buffered instruction toward if_id
//   inst_misalign_o             : (IFU_MISALIGN_CHK_EN only) head entry is a
//                                 misaligned-target marker, not a real fetch
// Handshake: a fetch is transferred on a cycle where ibus_req_o && ibus_gnt_i;
// the request is not held for a grant, so ibus_addr_o may change while
// ibus_req_o stays high. if_id takes the head on inst_valid_o && !stall_i.
// Optional build macro: IFU_MISALIGN_CHK_EN.
// ---------------------------------------------------------------------------
module ifu_pc
   import ifu_pc_pkg::*;
#(
   parameter inst_addr_bus_t RESET_ADDR = CPU_RESET_ADDR,
   parameter int             DEPTH      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_jump_en_i,
   input  logic [31:0] ex_jump_addr_i,
   input  logic        prd_jump_en_i,
   input  logic [31:0] prd_jump_base_i,
   input  logic [31:0] prd_jump_ofset_i,
   input  logic        stall_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
`ifdef IFU_MISALIGN_CHK_EN
   output logic        inst_misalign_o,
`endif
   output logic [31:0] instaddr_o
);

   localparam int          CW        = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_CNT = DEPTH[CW:0];

   inst_addr_bus_t pc;
   logic           epoch;
   logic           redirect;
   inst_addr_bus_t prd_target;
   inst_addr_bus_t raw_target;
   inst_addr_bus_t target;
   logic           grant;
   logic           rsp_keep;
   logic [CW:0]    occupancy;

   tag_t           tag_wdata;
   tag_t           tag_head;
   logic           tag_empty;
   logic [CW-1:0]  tag_cnt;

   buf_t           buf_wdata;
   buf_t           buf_head;
   logic           buf_empty;
   logic           buf_push;
   logic           buf_pop;
   logic [CW-1:0]  buf_cnt;

`ifdef IFU_MISALIGN_CHK_EN
   logic           halt;
   logic           target_misalign;
`endif

   assign redirect   = (ex_jump_en_i == JUMP_ENABLE) || (prd_jump_en_i == JUMP_ENABLE);
   assign prd_target = prd_jump_base_i + prd_jump_ofset_i;
   assign raw_target = (ex_jump_en_i == JUMP_ENABLE) ? ex_jump_addr_i : prd_target;
   assign target     = align_target(raw_target);

   // Outstanding fetches plus buffered instructions; bounding this by DEPTH
   // guarantees every response has a buffer slot waiting for it.
   assign occupancy = {1'b0, tag_cnt} + {1'b0, buf_cnt};

`ifdef IFU_MISALIGN_CHK_EN
   assign target_misalign = target[1];
   assign ibus_req_o      = !rst && !halt && (occupancy < DEPTH_CNT);
`else
   assign ibus_req_o      = !rst && (occupancy < DEPTH_CNT);
`endif

   assign ibus_addr_o = pc;
   assign grant       = ibus_req_o && ibus_gnt_i;

   // Each grant records the epoch it was issued under; a response is only
   // kept if no redirect has happened since and none is happening right now.
   assign tag_wdata = '{epoch: epoch, addr: pc};
   assign rsp_keep  = ibus_rvalid_i && !tag_empty && (tag_head.epoch == epoch) && !redirect;

   ifu_fifo #(
      .WIDTH ($bits(tag_t)),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (grant),
      .wdata (tag_wdata),
      .pop   (ibus_rvalid_i),
      .rdata (tag_head),
      .empty (tag_empty),
      .count (tag_cnt)
   );

   always_comb begin
      buf_wdata      = '0;
      buf_wdata.inst = ibus_rdata_i;
      buf_wdata.addr = tag_head.addr;
      buf_push       = rsp_keep;
`ifdef IFU_MISALIGN_CHK_EN
      // A misaligned redirect target is reported through the buffer as a
      // NOP marker instead of being fetched.
      if (redirect && target_misalign) begin
         buf_wdata.misalign = 1'b1;
         buf_wdata.inst     = IFU_NOP;
         buf_wdata.addr     = target;
         buf_push           = 1'b1;
      end
`endif
   end

   assign buf_pop = !buf_empty && !stall_i;

   ifu_fifo #(
      .WIDTH ($bits(buf_t)),
      .DEPTH (DEPTH)
   ) u_inst_buf (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect),
      .push  (buf_push),
      .wdata (buf_wdata),
      .pop   (buf_pop),
      .rdata (buf_head),
      .empty (buf_empty),
      .count (buf_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_ADDR;
         epoch <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
         halt  <= 1'b0;
`endif
      end else if (redirect) begin
         pc    <= target;
         epoch <= ~epoch;
`ifdef IFU_MISALIGN_CHK_EN
         halt  <= target_misalign;
`endif
      end else if (grant) begin
         pc    <= pc + 32'd4;
      end
   end

   assign inst_valid_o = !buf_empty;
   assign inst_o       = buf_empty ? IFU_NOP    : buf_head.inst;
   assign instaddr_o   = buf_empty ? RESET_ADDR : buf_head.addr;
`ifdef IFU_MISALIGN_CHK_EN
   assign inst_misalign_o = !buf_empty && buf_head.misalign;
`endif

endmodule

// File: tb/tb_ifu_pc.sv
// ---------------------------------------------------------------------------
// tb_ifu_pc
// Bench for ifu_pc (DEPTH=2, RESET_ADDR=0). A bus responder answers grants in
// order after a random latency; a queue-based model of the fetch rules gives
// the expected outputs every cycle. Directed sequences and a target table
// cover reset, redirects, stalls and wrap-around.
// ---------------------------------------------------------------------------
module tb_ifu_pc;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] RST_A = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        ex_jump_en_i;
   logic [31:0] ex_jump_addr_i;
   logic        prd_jump_en_i;
   logic [31:0] prd_jump_base_i;
   logic [31:0] prd_jump_ofset_i;
   logic        stall_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] instaddr_o;
`ifdef IFU_MISALIGN_CHK_EN
   logic        inst_misalign_o;
`endif

   ifu_pc #(
      .RESET_ADDR (RST_A),
      .DEPTH      (DEPTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .ex_jump_en_i     (ex_jump_en_i),
      .ex_jump_addr_i   (ex_jump_addr_i),
      .prd_jump_en_i    (prd_jump_en_i),
      .prd_jump_base_i  (prd_jump_base_i),
      .prd_jump_ofset_i (prd_jump_ofset_i),
      .stall_i          (stall_i),
      .ibus_req_o       (ibus_req_o),
      .ibus_addr_o      (ibus_addr_o),
      .ibus_gnt_i       (ibus_gnt_i),
      .ibus_rvalid_i    (ibus_rvalid_i),
      .ibus_rdata_i     (ibus_rdata_i),
      .inst_valid_o     (inst_valid_o),
      .inst_o           (inst_o),
`ifdef IFU_MISALIGN_CHK_EN
      .inst_misalign_o  (inst_misalign_o),
`endif
      .instaddr_o       (instaddr_o)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model / scoreboard state ----------------
   typedef struct { logic ep; logic [31:0] addr; }                 tag_s;
   typedef struct { logic [31:0] data; logic [31:0] addr; logic mis; } ent_s;
   typedef struct { logic [31:0] addr; int ready; }                rsp_s;
   typedef struct {
      logic        ex_en;
      logic [31:0] ex_a;
      logic        prd_en;
      logic [31:0] b;
      logic [31:0] o;
      logic [31:0] exp_addr;
   } vec_s;

   tag_s        m_tag_q[$];
   ent_s        m_buf_q[$];
   rsp_s        bus_q[$];
   logic [31:0] dlv_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] m_pc;
   logic        m_ep;
   logic        m_halt;
   logic        m_known;
   int          n_cmp;
   int          n_err;
   int          cyc;
   int          lat_max;
   int          rv_pct;
   vec_s        vecs[7];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // {misaligned, target} from the redirect rules.
   function automatic logic [32:0] tgt(input logic exe, input logic [31:0] exa,
                                       input logic [31:0] b, input logic [31:0] o);
      logic [31:0] raw;
      raw = exe ? exa : (b + o);
`ifdef IFU_MISALIGN_CHK_EN
      return {raw[1], raw & ~32'h1};
`else
      return {1'b0, raw & ~32'h3};
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- one clock cycle: drive, compare, advance model ----------------
   task automatic cycle(input logic r, input logic exe, input logic [31:0] exa,
                        input logic prde, input logic [31:0] b, input logic [31:0] o,
                        input logic st, input logic g);
      logic [32:0] t;
      logic        red;
      logic        grant;
      logic        rv;
      logic        keep;
      logic        exp_req;
      logic [31:0] rd;
      logic [31:0] rv_addr;
      tag_s        tg;
      rsp_s        rs;
      ent_s        e;

      @(negedge clk);
      rst              = r;
      ex_jump_en_i     = exe;
      ex_jump_addr_i   = exa;
      prd_jump_en_i    = prde;
      prd_jump_base_i  = b;
      prd_jump_ofset_i = o;
      stall_i          = st;
      ibus_gnt_i       = g;
      rv = 1'b0;
      rd = '0;
      if (bus_q.size() > 0 && bus_q[0].ready <= cyc && $urandom_range(99) < rv_pct) begin
         rs = bus_q.pop_front();
         rv = 1'b1;
         rd = mem_word(rs.addr);
      end
      ibus_rvalid_i = rv;
      ibus_rdata_i  = rd;
      #1;

      exp_req = 1'b0;
      if (m_known) begin
         exp_req = !r && !m_halt && ((m_tag_q.size() + m_buf_q.size()) < DEPTH);
         check("ibus_req", {31'b0, ibus_req_o}, {31'b0, exp_req});
         check("ibus_addr", ibus_addr_o, m_pc);
         check("inst_valid", {31'b0, inst_valid_o}, {31'b0, (m_buf_q.size() > 0)});
         if (m_buf_q.size() > 0) begin
            e = m_buf_q[0];
            check("inst", inst_o, e.data);
            check("instaddr", instaddr_o, e.addr);
`ifdef IFU_MISALIGN_CHK_EN
            check("inst_misalign", {31'b0, inst_misalign_o}, {31'b0, e.mis});
`endif
         end else begin
            check("inst_idle", inst_o, NOP);
            check("instaddr_idle", instaddr_o, RST_A);
         end
      end

      if (inst_valid_o && !st && !r) dlv_q.push_back(instaddr_o);
      if (ibus_req_o && g) bus_q.push_back('{addr: ibus_addr_o, ready: cyc + 1 + $urandom_range(lat_max)});

      if (r) begin
         m_tag_q.delete();
         m_buf_q.delete();
         m_pc    = RST_A;
         m_ep    = 1'b0;
         m_halt  = 1'b0;
         m_known = 1'b1;
      end else begin
         t       = tgt(exe, exa, b, o);
         red     = exe || prde;
         grant   = exp_req && g;
         keep    = 1'b0;
         rv_addr = '0;
         if (rv && m_tag_q.size() > 0) begin
            tg      = m_tag_q.pop_front();
            keep    = (tg.ep == m_ep) && !red;
            rv_addr = tg.addr;
         end
         if (grant) m_tag_q.push_back('{ep: m_ep, addr: m_pc});
         if (m_buf_q.size() > 0 && !st && !red) e = m_buf_q.pop_front();
         if (keep) m_buf_q.push_back('{data: mem_word(rv_addr), addr: rv_addr, mis: 1'b0});
         if (red) begin
            m_buf_q.delete();
            if (t[32]) m_buf_q.push_back('{data: NOP, addr: t[31:0], mis: 1'b1});
            m_halt = t[32];
            m_pc   = t[31:0];
            m_ep   = ~m_ep;
         end else if (grant) begin
            m_pc = m_pc + 32'd4;
         end
      end
      cyc++;
      @(posedge clk);
   endtask

   // ---------------- driver helpers ----------------
   task automatic idle(input int n, input logic st);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, st, 1'b1);
   endtask

   // Reset, then let responses to pre-reset fetches come back with no new
   // grants so they are seen (and ignored) before fresh traffic starts.
   task automatic do_reset();
      int saved;
      cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      saved  = rv_pct;
      rv_pct = 100;
      for (int i = 0; i < 8 && bus_q.size() > 0; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      rv_pct = saved;
   endtask

   task automatic check_dlv(input string name);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < dlv_q.size()) begin
            check(name, dlv_q[i], exp_q[i]);
         end else begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: instruction %0d never delivered, expected addr %h", name, i, exp_q[i]);
         end
      end
   endtask

   // ---------------- test ----------------
   initial begin
      logic [31:0] hold_addr;
      logic        seen8;
      int          p;

      n_cmp = 0; n_err = 0; cyc = 0;
      lat_max = 0; rv_pct = 100;
      m_known = 1'b0; m_halt = 1'b0; m_ep = 1'b0; m_pc = '0;
      rst = 1'b1; ex_jump_en_i = 1'b0; ex_jump_addr_i = '0; prd_jump_en_i = 1'b0;
      prd_jump_base_i = '0; prd_jump_ofset_i = '0; stall_i = 1'b0;
      ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;

      vecs[0] = '{1'b0, 32'h0, 1'b1, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0000_00F0};
      vecs[1] = '{1'b0, 32'h0, 1'b1, 32'hFFFF_FFF0, 32'h0000_000C, 32'hFFFF_FFFC};
      vecs[2] = '{1'b0, 32'h0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
      vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h1234_5671, 32'h0000_0000, 32'h1234_5670};
      vecs[4] = '{1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 32'h0, 32'h0000_0200};
`ifdef IFU_MISALIGN_CHK_EN
      vecs[5] = '{1'b0, 32'h0, 1'b1, 32'h0000_1000, 32'h0000_0003, 32'h0000_1002};
      vecs[6] = '{1'b0, 32'h0, 1'b1, 32'h0000_0007, 32'h0000_0000, 32'h0000_0006};
`else
      vecs[5] = '{1'b0, 32'h0, 1'b1, 32'h0000_1000, 32'h0000_0003, 32'h0000_1000};
      vecs[6] = '{1'b0, 32'h0, 1'b1, 32'h0000_0007, 32'h0000_0000, 32'h0000_0004};
`endif

      // 1: reset state and first fetches with a 1-cycle bus
      cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      #2;
      check("rst_req", {31'b0, ibus_req_o}, 32'd0);
      check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
      check("rst_inst", inst_o, NOP);
      check("rst_instaddr", instaddr_o, RST_A);
      check("rst_pc", ibus_addr_o, RST_A);
      dlv_q.delete();
      idle(1, 1'b0);
      #2 check("first_valid_early", {31'b0, inst_valid_o}, 32'd0);
      idle(1, 1'b0);
      #2 check("first_valid", {31'b0, inst_valid_o}, 32'd1);
      check("first_addr", instaddr_o, 32'h0);
      check("first_inst", inst_o, mem_word(32'h0));
      idle(10, 1'b0);
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      check_dlv("seq_stream");

      // 2: predicted jump while the fetch to 0x8 is in flight
      do_reset();
      dlv_q.delete();
      idle(4, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b1, 32'h0000_0100, 32'hFFFF_FFF0, 1'b0, 1'b1);
      #2 check("prd_target", ibus_addr_o, 32'h0000_00F0);
      idle(12, 1'b0);
      seen8 = 1'b0;
      foreach (dlv_q[i]) if (dlv_q[i] == 32'h8) seen8 = 1'b1;
      check("stale_dropped", {31'b0, seen8}, 32'd0);
      exp_q = '{32'h0, 32'h4, 32'hF0, 32'hF4};
      check_dlv("prd_stream");

      // 3: EX redirect beats the predicted one and flushes the buffer
      do_reset();
      idle(3, 1'b0);
      cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 32'h0, 1'b0, 1'b1);
      #2 check("ex_priority", ibus_addr_o, 32'h0000_0200);
      check("flush_valid", {31'b0, inst_valid_o}, 32'd0);
      idle(6, 1'b0);

      // 4: stall fills the window; head holds; release drains in order
      do_reset();
      dlv_q.delete();
      idle(2, 1'b1);
      hold_addr = instaddr_o;
      for (int i = 0; i < 5; i++) begin
         idle(1, 1'b1);
         #2;
         check("stall_req", {31'b0, ibus_req_o}, 32'd0);
         check("stall_addr", instaddr_o, 32'h0);
         check("stall_inst", inst_o, mem_word(32'h0));
      end
      check("stall_hold_start", hold_addr, 32'h0);
      idle(10, 1'b0);
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      check_dlv("stall_stream");

      // 5: predicted target at the top of memory, sequential fetch wraps
      do_reset();
      idle(2, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFF0, 32'h0000_000C, 1'b0, 1'b1);
      #2 check("wrap_target", ibus_addr_o, 32'hFFFF_FFFC);
      dlv_q.delete();
      idle(1, 1'b0);
      #2 check("wrap_pc", ibus_addr_o, 32'h0000_0000);
      idle(8, 1'b0);
      exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
      check_dlv("wrap_stream");

`ifdef IFU_MISALIGN_CHK_EN
      // 6: misaligned redirect target becomes a NOP marker, fetching stops
      do_reset();
      idle(3, 1'b0);
      cycle(1'b0, 1'b1, 32'h0000_0102, 1'b0, '0, '0, 1'b0, 1'b1);
      #2;
      check("mis_valid", {31'b0, inst_valid_o}, 32'd1);
      check("mis_flag", {31'b0, inst_misalign_o}, 32'd1);
      check("mis_addr", instaddr_o, 32'h0000_0102);
      check("mis_inst", inst_o, NOP);
      check("mis_req", {31'b0, ibus_req_o}, 32'd0);
      idle(4, 1'b0);
      #2 check("mis_hold_req", {31'b0, ibus_req_o}, 32'd0);
      cycle(1'b0, 1'b1, 32'h0000_0040, 1'b0, '0, '0, 1'b0, 1'b1);
      idle(4, 1'b0);
`endif

      // target table
      do_reset();
      foreach (vecs[i]) begin
         cycle(1'b0, vecs[i].ex_en, vecs[i].ex_a, vecs[i].prd_en, vecs[i].b, vecs[i].o, 1'b0, 1'b1);
         #2 check("tbl_target", ibus_addr_o, vecs[i].exp_addr);
         idle(2, 1'b0);
      end

      // randomized traffic against the model
      lat_max = 3;
      rv_pct  = 75;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         p = $urandom_range(999);
         if (p < 3) begin
            do_reset();
         end else begin
            cycle(1'b0, ($urandom_range(99) < 3), $urandom(), ($urandom_range(99) < 5),
                  $urandom(), $urandom(), ($urandom_range(99) < 30), ($urandom_range(99) < 70));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
